// File: rtl/password_entry_buffer_pkg.sv
// Shared constants, key codes and state encoding for the password entry buffer.
package password_entry_buffer_pkg;

    localparam int unsigned PW_WIDTH = 128;
    localparam logic [PW_WIDTH-1:0] PW_BLANK = '1;

    localparam logic [3:0] KEY_BACKSPACE = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hB;
    localparam logic [3:0] KEY_ENTER     = 4'hF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StEntry   = 2'd1,
        StConfirm = 2'd2
    } state_e;

    function automatic logic key_is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // 0xC-0xE are not keys at all; everything else is acted on.
    function automatic logic key_is_known(input logic [3:0] code);
        return key_is_digit(code) || (code == KEY_BACKSPACE) || (code == KEY_CLEAR) ||
               (code == KEY_ENTER);
    endfunction

endpackage

// File: rtl/password_entry_buffer_inactivity_timer.sv
// Idle-cycle counter: runs while enabled, restarts on a kick, flags the last idle cycle.
module password_entry_buffer_inactivity_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic kick_i,
    output logic expire_o
);

    localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LastCnt = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_d, cnt_q;

    // Count idle cycles; any kick, stop or expiry restarts from zero.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (!run_i || kick_i || (cnt_q == LastCnt)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && (cnt_q == LastCnt);

endmodule

// File: rtl/password_entry_buffer.sv
// Collects keypad digits into a 128-bit F-padded password word and strobes confirm on ENTER.
module password_entry_buffer
    import password_entry_buffer_pkg::*;
#(
    parameter int unsigned MAX_DIGITS     = 32,
    parameter int unsigned MIN_DIGITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid_i,
    input  logic [3:0]          key_code_i,
    output logic [PW_WIDTH-1:0] pw_buf_o,
    output logic [5:0]          digit_count_o,
    output logic                confirm_o,
    output logic                entry_active_o,
    output logic                too_short_o,
    output logic                overflow_o
);

    localparam logic [5:0] MaxCnt = 6'(MAX_DIGITS);
    localparam logic [5:0] MinCnt = 6'(MIN_DIGITS);

    state_e              state_d, state_q;
    logic [PW_WIDTH-1:0] buf_d, buf_q;
    logic [5:0]          cnt_d, cnt_q;
    logic                confirm_d, confirm_q;
    logic                too_short_d, too_short_q;
    logic                overflow_d, overflow_q;
    logic                key_accept;
    logic                expire;

    // Keys are dropped during the confirm cycle and unknown codes never count as activity.
    assign key_accept = key_valid_i && key_is_known(key_code_i) && (state_q != StConfirm);

    password_entry_buffer_inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_i   (state_q == StEntry),
        .kick_i  (key_accept),
        .expire_o(expire)
    );

    // Next-state: key handling, ENTER length check, post-confirm clear and timeout.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        confirm_d   = 1'b0;
        too_short_d = 1'b0;
        overflow_d  = overflow_q;

        if (state_q == StConfirm) begin
            state_d    = StIdle;
            buf_d      = PW_BLANK;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else if (key_accept) begin
            if (key_is_digit(key_code_i)) begin
                if (cnt_q < MaxCnt) begin
                    buf_d   = {buf_q[PW_WIDTH-5:0], key_code_i};
                    cnt_d   = cnt_q + 6'd1;
                    state_d = StEntry;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (key_code_i == KEY_BACKSPACE) begin
                if (cnt_q != '0) begin
                    buf_d   = {4'hF, buf_q[PW_WIDTH-1:4]};
                    cnt_d   = cnt_q - 6'd1;
                    state_d = (cnt_q == 6'd1) ? StIdle : StEntry;
                end
            end else if ((key_code_i == KEY_ENTER) && (cnt_q >= MinCnt)) begin
                // Buffer holds through the confirm cycle so the comparators see it.
                state_d   = StConfirm;
                confirm_d = 1'b1;
            end else begin
                // CLEAR, or an ENTER that is too short.
                too_short_d = (key_code_i == KEY_ENTER);
                state_d     = StIdle;
                buf_d       = PW_BLANK;
                cnt_d       = '0;
                overflow_d  = 1'b0;
            end
        end else if (expire) begin
            state_d    = StIdle;
            buf_d      = PW_BLANK;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            buf_q       <= PW_BLANK;
            cnt_q       <= '0;
            confirm_q   <= 1'b0;
            too_short_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            confirm_q   <= confirm_d;
            too_short_q <= too_short_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pw_buf_o       = buf_q;
    assign digit_count_o  = cnt_q;
    assign confirm_o      = confirm_q;
    assign too_short_o    = too_short_q;
    assign overflow_o     = overflow_q;
    assign entry_active_o = (state_q == StEntry);

endmodule

// File: tb/tb_password_entry_buffer.sv
// Directed vector bench for password_entry_buffer.
module tb_password_entry_buffer;

    localparam logic [127:0] BLANK = '1;
    localparam logic [127:0] ALL7  = {32{4'h7}};

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic [3:0]   key_code;
    logic [127:0] pw_buf;
    logic [5:0]   digit_count;
    logic         confirm;
    logic         entry_active;
    logic         too_short;
    logic         overflow;

    int n_checks = 0;
    int n_pass   = 0;

    password_entry_buffer #(
        .MAX_DIGITS    (32),
        .MIN_DIGITS    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid_i   (key_valid),
        .key_code_i    (key_code),
        .pw_buf_o      (pw_buf),
        .digit_count_o (digit_count),
        .confirm_o     (confirm),
        .entry_active_o(entry_active),
        .too_short_o   (too_short),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         kv;
        logic [3:0]   code;
        logic [127:0] pw;
        logic [5:0]   cnt;
        logic         conf;
        logic         ts;
        logic         ov;
        logic         act;
    } vec_t;

    vec_t vecs[$];

    // F-padded word whose lowest n nibbles come from low.
    function automatic logic [127:0] pw_of(input logic [127:0] low, input int n);
        logic [127:0] r;
        r = '1;
        for (int i = 0; i < n; i++) r[4*i +: 4] = low[4*i +: 4];
        return r;
    endfunction

    function automatic logic [137:0] outs();
        return {pw_buf, digit_count, confirm, too_short, overflow, entry_active};
    endfunction

    function automatic logic [137:0] pack(input logic [127:0] pw, input logic [5:0] cnt,
                                          input logic conf, input logic ts, input logic ov,
                                          input logic act);
        return {pw, cnt, conf, ts, ov, act};
    endfunction

    task automatic add(input logic kv, input logic [3:0] code, input logic [127:0] low,
                       input int n, input logic conf, input logic ts, input logic ov,
                       input logic act);
        vec_t v;
        v.kv   = kv;
        v.code = code;
        v.pw   = pw_of(low, n);
        v.cnt  = 6'(n);
        v.conf = conf;
        v.ts   = ts;
        v.ov   = ov;
        v.act  = act;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [137:0] got, input logic [137:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pw=%h cnt=%0d conf/ts/ov/act=%b expected pw=%h cnt=%0d conf/ts/ov/act=%b",
                     name, got[137:10], got[9:4], got[3:0], exp[137:10], exp[9:4], exp[3:0]);
        end
    endtask

    // One cycle of stimulus; outputs are settled 1 time unit after the edge.
    task automatic cyc(input logic kv, input logic [3:0] code);
        key_valid = kv;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        #12;
        check("reset", outs(), pack(BLANK, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic accepted password, then the post-confirm clear.
        add(1, 4'h1, 128'h1,    1, 0, 0, 0, 1);
        add(1, 4'h2, 128'h12,   2, 0, 0, 0, 1);
        add(1, 4'h3, 128'h123,  3, 0, 0, 0, 1);
        add(1, 4'h4, 128'h1234, 4, 0, 0, 0, 1);
        add(1, 4'hF, 128'h1234, 4, 1, 0, 0, 0);
        add(0, 4'h0, 128'h0,    0, 0, 0, 0, 0);
        // Too short.
        add(1, 4'h1, 128'h1,    1, 0, 0, 0, 1);
        add(1, 4'h2, 128'h12,   2, 0, 0, 0, 1);
        add(1, 4'h3, 128'h123,  3, 0, 0, 0, 1);
        add(1, 4'hF, 128'h0,    0, 0, 1, 0, 0);
        add(0, 4'h0, 128'h0,    0, 0, 0, 0, 0);
        // Backspace inside an entry.
        add(1, 4'h5, 128'h5,    1, 0, 0, 0, 1);
        add(1, 4'h6, 128'h56,   2, 0, 0, 0, 1);
        add(1, 4'h7, 128'h567,  3, 0, 0, 0, 1);
        add(1, 4'hA, 128'h56,   2, 0, 0, 0, 1);
        add(1, 4'h8, 128'h568,  3, 0, 0, 0, 1);
        add(1, 4'h9, 128'h5689, 4, 0, 0, 0, 1);
        add(1, 4'hF, 128'h5689, 4, 1, 0, 0, 0);
        add(0, 4'h0, 128'h0,    0, 0, 0, 0, 0);
        // Empty-buffer no-ops: backspace, unknown code, clear, ENTER with 0 digits.
        add(1, 4'hA, 128'h0,    0, 0, 0, 0, 0);
        add(1, 4'hC, 128'h0,    0, 0, 0, 0, 0);
        add(1, 4'hB, 128'h0,    0, 0, 0, 0, 0);
        add(1, 4'hF, 128'h0,    0, 0, 1, 0, 0);
        // Backspace down to empty returns to idle; "0" vs "00".
        add(1, 4'h0, 128'h0,    1, 0, 0, 0, 1);
        add(1, 4'h0, 128'h00,   2, 0, 0, 0, 1);
        add(1, 4'hA, 128'h0,    1, 0, 0, 0, 1);
        add(1, 4'hA, 128'h0,    0, 0, 0, 0, 0);
        // Key during the confirm cycle is dropped.
        add(1, 4'h9, 128'h9,    1, 0, 0, 0, 1);
        add(1, 4'h8, 128'h98,   2, 0, 0, 0, 1);
        add(1, 4'h7, 128'h987,  3, 0, 0, 0, 1);
        add(1, 4'h6, 128'h9876, 4, 0, 0, 0, 1);
        add(1, 4'hE, 128'h9876, 4, 0, 0, 0, 1);
        add(1, 4'hF, 128'h9876, 4, 1, 0, 0, 0);
        add(1, 4'h5, 128'h0,    0, 0, 0, 0, 0);
        add(0, 4'h0, 128'h0,    0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].kv, vecs[i].code);
            check($sformatf("vec%0d", i), outs(),
                  pack(vecs[i].pw, vecs[i].cnt, vecs[i].conf, vecs[i].ts, vecs[i].ov,
                       vecs[i].act));
        end

        // Fill to capacity, overflow, backspace keeps overflow, clear drops it.
        for (int i = 0; i < 32; i++) cyc(1'b1, 4'h7);
        check("fill32", outs(), pack(ALL7, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc(1'b1, 4'h7);
        check("overflow", outs(), pack(ALL7, 6'd32, 1'b0, 1'b0, 1'b1, 1'b1));
        cyc(1'b1, 4'hA);
        check("bs_full", outs(), pack({4'hF, ALL7[127:4]}, 6'd31, 1'b0, 1'b0, 1'b1, 1'b1));
        cyc(1'b1, 4'hB);
        check("clear_ov", outs(), pack(BLANK, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Timeout: 15 idle cycles keep the entry, the 16th clears it.
        cyc(1'b1, 4'h3);
        for (int i = 0; i < 15; i++) cyc(1'b0, 4'h0);
        check("to_before", outs(), pack(pw_of(128'h3, 1), 6'd1, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc(1'b0, 4'h0);
        check("to_expire", outs(), pack(BLANK, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // A key on the expiry cycle wins and restarts the count.
        cyc(1'b1, 4'h3);
        for (int i = 0; i < 15; i++) cyc(1'b0, 4'h0);
        cyc(1'b1, 4'h4);
        check("to_keywin", outs(), pack(pw_of(128'h34, 2), 6'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 15; i++) cyc(1'b0, 4'h0);
        check("to_restart", outs(), pack(pw_of(128'h34, 2), 6'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        // An unknown code on the expiry cycle does not save it.
        cyc(1'b1, 4'hD);
        check("to_invalid", outs(), pack(BLANK, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset during the confirm cycle kills confirm at once.
        cyc(1'b1, 4'h1);
        cyc(1'b1, 4'h2);
        cyc(1'b1, 4'h3);
        cyc(1'b1, 4'h4);
        cyc(1'b1, 4'hF);
        check("rst_pre", outs(), pack(pw_of(128'h1234, 4), 6'd4, 1'b1, 1'b0, 1'b0, 1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_confirm", outs(), pack(BLANK, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 4'h0);
        check("rst_after", outs(), pack(BLANK, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
